// File: rtl/mac_feeder.sv
// Operand sequencer for macfinal: buffers host quadruples in a FIFO and, on start,
// clears the MAC, streams the buffered entries, drains the MAC latency and captures acc.
module mac_feeder #(
  parameter int DEPTH = 8,
  parameter int LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [3:0]                   wr_a,
  input  logic [3:0]                   wr_b,
  input  logic [3:0]                   wr_c,
  input  logic [3:0]                   wr_d,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf,
  input  logic                         start,
  output logic [3:0]                   A,
  output logic [3:0]                   B,
  output logic [3:0]                   C,
  output logic [3:0]                   D,
  output logic                         mac_rst,
  input  logic [9:0]                   acc,
  output logic [9:0]                   result,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

  state_t          state;
  logic [15:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   rem;
  logic [LW-1:0]   dcnt;
  logic            empty_run;
  logic            push;
  logic            pop;

  assign full = (count == CW'(DEPTH));
  assign push = wr_en && !full;

  always_comb begin
    pop = 1'b0;
    if (state == CLEAR) pop = 1'b1;
    else if (state == ISSUE && rem != '0) pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_a, wr_b, wr_c, wr_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      ovf <= wr_en && full;
    end
  end

  // The first pop happens on the edge leaving CLEAR so entry k is on A..D during cycle ek.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rem       <= '0;
      dcnt      <= '0;
      empty_run <= 1'b0;
      {A, B, C, D} <= '0;
      mac_rst   <= 1'b1;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done         <= 1'b0;
      mac_rst      <= 1'b0;
      {A, B, C, D} <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            rem  <= count;
            if (count == '0) begin
              // Empty run takes a one-cycle detour through DRAIN so done lands in e1-e2.
              empty_run <= 1'b1;
              dcnt      <= '0;
              state     <= DRAIN;
            end else begin
              empty_run <= 1'b0;
              mac_rst   <= 1'b1;
              state     <= CLEAR;
            end
          end
        end
        CLEAR: begin
          {A, B, C, D} <= mem[rd_ptr];
          rem          <= rem - CW'(1);
          state        <= ISSUE;
        end
        ISSUE: begin
          if (rem != '0) begin
            {A, B, C, D} <= mem[rd_ptr];
            rem          <= rem - CW'(1);
          end else begin
            dcnt  <= LW'(LAT - 1);
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt == '0) begin
            result <= empty_run ? '0 : acc;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            dcnt <= dcnt - LW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
